keypad_scan_entry: RTL and testbench

- Input-side counterpart of the board's seven-segment display driver.
- Scans a 4x4 active-low matrix keypad one row at a time and debounces the column lines.
- Decodes each confirmed keypress to a 4-bit hex code and shifts it into a 32-bit entry register.
- The entry register feeds the display's 32-bit number input, so typed hex digits appear on the display.

---
 rtl/keypad_pkg.sv | 29 ++
 rtl/keypad_decode.sv | 27 ++
 rtl/keypad_scan_entry.sv | 171 +++++++++++++++++
 tb/tb_keypad_scan_entry.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM state encoding, the
// {row, col} -> hex key map and the one-cold row drive constants.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   localparam logic [3:0] ROW_IDLE = 4'b1110;
   localparam logic [3:0] COL_IDLE = 4'hF;

   // Indexed by {row_idx, col_idx}; entry 0 is row0/col0.
   localparam logic [15:0][3:0] KEY_MAP = {
      4'hD, 4'hF, 4'h0, 4'hE,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   // One-cold drive for a row: ROW_IDLE rotated left by idx.
   function automatic logic [3:0] row_drive(input logic [1:0] idx);
      logic [7:0] dbl;
      dbl = {ROW_IDLE, ROW_IDLE} << idx;
      return dbl[7:4];
   endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational key decode: {row index, column pattern} -> hex code, plus a
// flag that is high only when exactly one column line is low.
module keypad_decode
   import keypad_pkg::*;
(
   input  logic [1:0] row_idx,
   input  logic [3:0] col,
   output logic [3:0] code,
   output logic       single_low
);

   logic [1:0] col_idx;

   always_comb begin
      col_idx    = 2'd0;
      single_low = 1'b1;
      case (col)
         4'b1110: col_idx = 2'd0;
         4'b1101: col_idx = 2'd1;
         4'b1011: col_idx = 2'd2;
         4'b0111: col_idx = 2'd3;
         default: single_low = 1'b0;
      endcase
      code = KEY_MAP[{row_idx, col_idx}];
   end

endmodule

// File: rtl/keypad_scan_entry.sv
// 4x4 keypad scanner with debounce, hex decode and a 32-bit digit entry register.
// Define KEYPAD_REPEAT_EN to add auto-repeat while a key stays held.
module keypad_scan_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 250000,
   parameter int REPEAT_CNT   = 25000000
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [3:0]  COL,
   input  logic        entry_clr,
   output logic [3:0]  ROW,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_down,
   output logic [31:0] entry
);

   localparam int SW = $clog2(SCAN_DIV);
   localparam int DW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CNT - 1);

   if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 1) begin : g_param_chk
      $error("keypad_scan_entry: parameter out of range");
   end

   state_t        state_q, state_d;
   logic [1:0]    row_idx_q, row_idx_d;
   logic [3:0]    col_q, col_d;
   logic [SW-1:0] scnt_q, scnt_d;
   logic [DW-1:0] dcnt_q, dcnt_d, rcnt_q, rcnt_d;
   logic [3:0]    code_q, code_d;
   logic          valid_q, valid_d, down_q, down_d;
   logic [31:0]   entry_q, entry_d;
   logic [3:0]    dec_col, dec_code;
   logic          dec_single, fire;

`ifdef KEYPAD_REPEAT_EN
   localparam int PW = $clog2(REPEAT_CNT + 1);
   localparam logic [PW-1:0] P_LAST = PW'(REPEAT_CNT - 1);
   logic [PW-1:0] pcnt_q, pcnt_d;
`endif

   // Live columns while scanning; the latched pattern once a key is captured.
   assign dec_col = (state_q == SCAN) ? COL : col_q;

   keypad_decode u_decode (
      .row_idx    (row_idx_q),
      .col        (dec_col),
      .code       (dec_code),
      .single_low (dec_single)
   );

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q   <= SCAN;
         row_idx_q <= 2'd0;
         col_q     <= COL_IDLE;
         scnt_q    <= '0;
         dcnt_q    <= '0;
         rcnt_q    <= '0;
         code_q    <= 4'h0;
         valid_q   <= 1'b0;
         down_q    <= 1'b0;
         entry_q   <= 32'h0;
`ifdef KEYPAD_REPEAT_EN
         pcnt_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         row_idx_q <= row_idx_d;
         col_q     <= col_d;
         scnt_q    <= scnt_d;
         dcnt_q    <= dcnt_d;
         rcnt_q    <= rcnt_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         down_q    <= down_d;
         entry_q   <= entry_d;
`ifdef KEYPAD_REPEAT_EN
         pcnt_q    <= pcnt_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      row_idx_d = row_idx_q;
      col_d     = col_q;
      scnt_d    = scnt_q;
      dcnt_d    = dcnt_q;
      rcnt_d    = rcnt_q;
      code_d    = code_q;
      valid_d   = 1'b0;
      down_d    = down_q;
      entry_d   = entry_clr ? 32'h0 : entry_q;
      fire      = 1'b0;
      case (state_q)
         SCAN: begin
            if (scnt_q == S_LAST) begin
               scnt_d = '0;
               if (dec_single) begin
                  col_d   = COL;
                  dcnt_d  = '0;
                  state_d = DEBOUNCE;
               end else begin
                  row_idx_d = row_idx_q + 2'd1;
               end
            end else begin
               scnt_d = scnt_q + SW'(1);
            end
         end
         DEBOUNCE: begin
            if (COL != col_q) begin
               row_idx_d = row_idx_q + 2'd1;
               scnt_d    = '0;
               state_d   = SCAN;
            end else if (dcnt_q == D_LAST) begin
               fire    = 1'b1;
               down_d  = 1'b1;
               rcnt_d  = '0;
               state_d = HELD;
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
         HELD: begin
            // Release needs DEBOUNCE_CNT consecutive all-high column cycles.
            if (COL != COL_IDLE) begin
               rcnt_d = '0;
            end else if (rcnt_q == D_LAST) begin
               down_d    = 1'b0;
               row_idx_d = row_idx_q + 2'd1;
               scnt_d    = '0;
               state_d   = SCAN;
            end else begin
               rcnt_d = rcnt_q + DW'(1);
            end
         end
         default: state_d = SCAN;
      endcase
`ifdef KEYPAD_REPEAT_EN
      pcnt_d = pcnt_q;
      if (state_q != HELD || (COL & ~col_q) != 4'h0) begin
         pcnt_d = '0;
      end else if (pcnt_q == P_LAST) begin
         pcnt_d = '0;
         fire   = 1'b1;
      end else begin
         pcnt_d = pcnt_q + PW'(1);
      end
`endif
      if (fire) begin
         valid_d = 1'b1;
         code_d  = dec_code;
         entry_d = entry_clr ? {28'h0, dec_code} : {entry_q[27:0], dec_code};
      end
   end

   always_comb begin
      ROW       = row_drive(row_idx_q);
      key_code  = code_q;
      key_valid = valid_q;
      key_down  = down_q;
      entry     = entry_q;
   end

endmodule

// File: tb/tb_keypad_scan_entry.sv
// Directed bench for keypad_scan_entry with a behavioural keypad matrix model;
// expectations differ with KEYPAD_REPEAT_EN only in the auto-repeat sequence.
module tb_keypad_scan_entry;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 8;
   localparam int REPEAT_CNT   = 20;

   typedef struct packed {
      logic [1:0]  row;
      logic [1:0]  col;
      logic        eclr;
      logic [3:0]  code;
      logic [31:0] entry;
   } vec_t;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        entry_clr = 1'b0;
   logic [3:0]  COL;
   logic [3:0]  ROW;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_down;
   logic [31:0] entry;

   logic        pressed = 1'b0;
   logic [1:0]  prow = 2'd0;
   logic [1:0]  pcol = 2'd0;
   logic        force_en = 1'b0;
   logic [3:0]  force_col = 4'hF;

   int total = 0;
   int bad   = 0;
   vec_t vecs [16];

   always #5 clk = ~clk;

   // Keypad matrix: a pressed key pulls its column low only while its row is driven.
   always_comb begin
      COL = 4'hF;
      if (force_en) COL = force_col;
      else if (pressed && !ROW[prow]) COL[pcol] = 1'b0;
   end

   keypad_scan_entry #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .REPEAT_CNT   (REPEAT_CNT)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .COL       (COL),
      .entry_clr (entry_clr),
      .ROW       (ROW),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_down  (key_down),
      .entry     (entry)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: timeout", name);
   endtask

   // Returns on the first negedge at which ROW becomes r.
   task automatic wait_row_fresh(input logic [3:0] r, input string name);
      int n = 0;
      while (ROW == r && n < 100) begin tick(); n++; end
      while (ROW != r && n < 100) begin tick(); n++; end
      if (n >= 100) timeout(name);
   endtask

   task automatic wait_valid(output int n, input string name);
      n = 0;
      while (!key_valid && n < 300) begin tick(); n++; end
      if (n >= 300) timeout(name);
   endtask

   task automatic wait_down_low(input string name);
      int n = 0;
      while (key_down && n < 60) begin tick(); n++; end
      if (n >= 60) timeout(name);
   endtask

   initial begin
      int n, nv, miss, npulse;
      logic [3:0]  er;
      logic [50:0] exp_mask;
      logic [31:0] exp_entry;

      vecs[0]  = '{2'd3, 2'd0, 1'b0, 4'hE, 32'h0000006E};
      vecs[1]  = '{2'd3, 2'd1, 1'b0, 4'h0, 32'h000006E0};
      vecs[2]  = '{2'd3, 2'd3, 1'b0, 4'hD, 32'h00006E0D};
      vecs[3]  = '{2'd2, 2'd1, 1'b0, 4'h8, 32'h0006E0D8};
      vecs[4]  = '{2'd2, 2'd2, 1'b0, 4'h9, 32'h006E0D89};
      vecs[5]  = '{2'd2, 2'd3, 1'b0, 4'hC, 32'h06E0D89C};
      vecs[6]  = '{2'd0, 2'd0, 1'b0, 4'h1, 32'h6E0D89C1};
      vecs[7]  = '{2'd0, 2'd1, 1'b0, 4'h2, 32'hE0D89C12};
      vecs[8]  = '{2'd0, 2'd2, 1'b0, 4'h3, 32'h0D89C123};
      vecs[9]  = '{2'd0, 2'd3, 1'b0, 4'hA, 32'hD89C123A};
      vecs[10] = '{2'd1, 2'd0, 1'b0, 4'h4, 32'h89C123A4};
      vecs[11] = '{2'd1, 2'd1, 1'b0, 4'h5, 32'h9C123A45};
      vecs[12] = '{2'd1, 2'd2, 1'b0, 4'h6, 32'hC123A456};
      vecs[13] = '{2'd1, 2'd3, 1'b0, 4'hB, 32'h123A456B};
      vecs[14] = '{2'd2, 2'd0, 1'b0, 4'h7, 32'h23A456B7};
      vecs[15] = '{2'd2, 2'd0, 1'b1, 4'h7, 32'h00000007};

      // Reset state
      repeat (3) tick();
      chk("rst_row", 32'(ROW), 32'hE);
      chk("rst_valid", 32'(key_valid), 32'h0);
      chk("rst_down", 32'(key_down), 32'h0);
      chk("rst_code", 32'(key_code), 32'h0);
      chk("rst_entry", entry, 32'h0);

      // Idle scan: 4 cycles per row, wrapping
      clr = 1'b1;
      nv = 0;
      for (int k = 0; k < 20; k++) begin
         if (k % 4 == 0) begin
            er = ~(4'b0001 << ((k / 4) % 4));
            chk($sformatf("idle_row_k%0d", k), 32'(ROW), 32'(er));
         end
         if (key_valid) nv++;
         tick();
      end
      chk("idle_no_valid", 32'(nv), 32'h0);
      chk("idle_entry", entry, 32'h0);

      // Row1/col2 press: exact latency and release debounce
      wait_row_fresh(4'b1110, "p6_sync");
      prow = 2'd1; pcol = 2'd2; pressed = 1'b1;
      wait_row_fresh(4'b1101, "p6_row");
      wait_valid(n, "p6_valid");
      chk("p6_latency", 32'(n), 32'd12);
      chk("p6_code", 32'(key_code), 32'h6);
      chk("p6_entry", entry, 32'h6);
      chk("p6_down", 32'(key_down), 32'h1);
      tick();
      chk("p6_pulse_width", 32'(key_valid), 32'h0);
      pressed = 1'b0;
      repeat (7) tick();
      chk("p6_down_7rel", 32'(key_down), 32'h1);
      tick();
      chk("p6_down_8rel", 32'(key_down), 32'h0);

      // Key map and entry shifting, last record clears alongside the key
      for (int i = 0; i < 16; i++) begin
         entry_clr = vecs[i].eclr;
         prow = vecs[i].row; pcol = vecs[i].col; pressed = 1'b1;
         wait_valid(n, $sformatf("tab%0d_valid", i));
         chk($sformatf("tab%0d_code", i), 32'(key_code), 32'(vecs[i].code));
         chk($sformatf("tab%0d_entry", i), entry, vecs[i].entry);
         entry_clr = 1'b0;
         tick();
         pressed = 1'b0;
         wait_down_low($sformatf("tab%0d_release", i));
      end

      // Bounce: 5 low cycles, 1 high, then a clean press on a later pass
      wait_row_fresh(4'b1110, "b_sync");
      force_col = 4'b1110; force_en = 1'b1; nv = 0;
      repeat (5) begin tick(); if (key_valid) nv++; end
      force_col = 4'hF;
      tick();
      if (key_valid) nv++;
      chk("b_row_adv", 32'(ROW), 32'hD);
      chk("b_no_valid", 32'(nv), 32'h0);
      force_en = 1'b0;
      prow = 2'd0; pcol = 2'd0; pressed = 1'b1;
      wait_valid(n, "b_valid");
      chk("b_code", 32'(key_code), 32'h1);
      chk("b_entry", entry, 32'h71);
      tick();
      pressed = 1'b0;
      wait_down_low("b_release");

      // Two columns low in one row
      wait_row_fresh(4'b1011, "tc_sync");
      force_col = 4'b1001; force_en = 1'b1; nv = 0;
      repeat (4) begin tick(); if (key_valid) nv++; end
      chk("tc_row_adv", 32'(ROW), 32'h7);
      repeat (16) begin tick(); if (key_valid) nv++; end
      chk("tc_no_valid", 32'(nv), 32'h0);
      force_en = 1'b0;

      // Reset in the middle of DEBOUNCE
      wait_row_fresh(4'b1110, "rd_sync");
      prow = 2'd1; pcol = 2'd1; pressed = 1'b1;
      wait_row_fresh(4'b1101, "rd_row");
      repeat (6) tick();
      clr = 1'b0;
      tick();
      chk("rd_row", 32'(ROW), 32'hE);
      chk("rd_valid", 32'(key_valid), 32'h0);
      chk("rd_down", 32'(key_down), 32'h0);
      chk("rd_entry", entry, 32'h0);
      clr = 1'b1; pressed = 1'b0; nv = 0;
      repeat (30) begin tick(); if (key_valid) nv++; end
      chk("rd_no_valid", 32'(nv), 32'h0);

      // Hold "F" for 50 cycles past confirmation
`ifdef KEYPAD_REPEAT_EN
      exp_mask = 51'h0;
      exp_mask[0] = 1'b1; exp_mask[20] = 1'b1; exp_mask[40] = 1'b1;
      exp_entry = 32'hFFF;
`else
      exp_mask = 51'h1;
      exp_entry = 32'hF;
`endif
      wait_row_fresh(4'b1110, "rp_sync");
      prow = 2'd3; pcol = 2'd2; pressed = 1'b1;
      wait_valid(n, "rp_valid");
      miss = 0; npulse = 0;
      for (int i = 0; i <= 50; i++) begin
         if (key_valid) npulse++;
         if (key_valid !== exp_mask[i]) miss++;
         tick();
      end
      chk("rp_pulse_count", 32'(npulse), 32'($countones(exp_mask)));
      chk("rp_pulse_timing", 32'(miss), 32'h0);
      pressed = 1'b0;
      wait_down_low("rp_release");
      chk("rp_code", 32'(key_code), 32'hF);
      chk("rp_entry", entry, exp_entry);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
